// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles each 32-bit instruction from four byte reads.
// Optional direct-mapped one-word cache, enabled with `define ICACHE_EN.
module if_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_state,
    input  logic        ex_b_flag_i,
    input  logic [31:0] ex_b_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic [7:0]  mem_din_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        stallreq_o
);

    typedef enum logic {FETCH, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [2:0]  issue_cnt_q, issue_cnt_d;
    logic [1:0]  recv_cnt_q, recv_cnt_d;
    logic        inflight_q, inflight_d;
    logic        hit;

    localparam logic [31:0] LINES_VEC = 32'(ICACHE_LINES);
    logic unused_ok;
    assign unused_ok = ^{stall_state[5:2], stall_state[0], LINES_VEC[0]};

`ifdef ICACHE_EN
    localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [ICACHE_LINES-1:0] valid_q;
    logic [TAG_W-1:0]        tag_q  [ICACHE_LINES];
    logic [31:0]             data_q [ICACHE_LINES];
    logic [IDX_W-1:0]        idx;
    logic [TAG_W-1:0]        tag;
    logic                    fill;

    assign idx = pc_q[2 +: IDX_W];
    assign tag = pc_q[31 -: TAG_W];
    // Lookup only on the first cycle of a fetch, before any byte has been issued.
    assign hit = (state_q == FETCH) && (issue_cnt_q == 3'd0) && (recv_cnt_q == 2'd0)
                 && !ex_b_flag_i && valid_q[idx] && (tag_q[idx] == tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= inst_d;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        inflight_d  = 1'b0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        if_pc_o     = pc_q;
        if_inst_o   = '0;
        stallreq_o  = 1'b0;
`ifdef ICACHE_EN
        fill        = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                stallreq_o = 1'b1;
                mem_req_o  = !hit && !issue_cnt_q[2];
                if (mem_req_o) begin
                    mem_addr_o = pc_q + {29'b0, issue_cnt_q};
                end
                if (mem_req_o && mem_gnt_i) begin
                    issue_cnt_d = issue_cnt_q + 3'd1;
                    inflight_d  = 1'b1;
                end
`ifdef ICACHE_EN
                if (hit) begin
                    inst_d  = data_q[idx];
                    state_d = DONE;
                end
`endif
                if (inflight_q) begin
                    inst_d[{recv_cnt_q, 3'b000} +: 8] = mem_din_i;
                    recv_cnt_d = recv_cnt_q + 2'd1;
                    if (recv_cnt_q == 2'd3) begin
                        state_d = DONE;
`ifdef ICACHE_EN
                        fill = 1'b1;
`endif
                    end
                end
            end
            DONE: begin
                if_inst_o = inst_q;
                if (!stall_state[1]) begin
                    pc_d        = pc_q + 32'd4;
                    state_d     = FETCH;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                end
            end
            default: state_d = FETCH;
        endcase

        // Redirect wins over completion, DONE advance and stall hold alike.
        if (ex_b_flag_i) begin
            pc_d        = ex_b_target_i;
            state_d     = FETCH;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            inflight_d  = 1'b0;
`ifdef ICACHE_EN
            fill        = 1'b0;
`endif
        end

        if (rst) begin
            mem_req_o  = 1'b0;
            mem_addr_o = '0;
            if_pc_o    = RESET_PC;
            if_inst_o  = '0;
            stallreq_o = 1'b0;
`ifdef ICACHE_EN
            fill       = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            inflight_q  <= inflight_d;
        end
    end

endmodule
